// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan path.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef logic [3:0] key_code_t;

  function automatic key_code_t pack_code(input logic [COL_W-1:0] col,
                                          input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side and key-encoder-side signals of the scan controller.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic                en_tick_i;
  logic [NUM_ROWS-1:0] fila_i;
  logic [COL_W-1:0]    col_o;
  key_code_t           key_code_o;
  logic                key_valid_o;
  logic                key_held_o;

  modport master (
    output en_tick_i, fila_i,
    input  col_o, key_code_o, key_valid_o, key_held_o
  );

  modport slave (
    input  en_tick_i, fila_i,
    output col_o, key_code_o, key_valid_o, key_held_o
  );

endinterface

// File: rtl/keypad_row_prio_enc.sv
// Lowest-index-wins encoder for the four row lines.
module keypad_row_prio_enc
  import keypad_pkg::*;
(
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [ROW_W-1:0]    idx_o,
  output logic                any_o
);

  // Priority encode: row 0 has highest priority.
  always_comb begin
    any_o = |row_i;
    idx_o = 2'd0;
    if (row_i[0]) begin
      idx_o = 2'd0;
    end else if (row_i[1]) begin
      idx_o = 2'd1;
    end else if (row_i[2]) begin
      idx_o = 2'd2;
    end else if (row_i[3]) begin
      idx_o = 2'd3;
    end else begin
      idx_o = 2'd0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner with press/release debounce; freezes the column while a key is down.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_TICKS = 4,
  parameter int REL_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  keypad_scan_ctrl_if.slave        bus
);

  localparam logic [7:0] DEB_LIM = 8'(DEB_TICKS);
  localparam logic [7:0] REL_LIM = 8'(REL_TICKS);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [7:0]       deb_cnt_q, deb_cnt_d;
  logic [7:0]       rel_cnt_q, rel_cnt_d;
  key_code_t        key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [ROW_W-1:0] enc_idx_s;
  logic             enc_any_s;
  logic             row_sel_s;
  logic [7:0]       deb_nxt_s;
  logic [7:0]       rel_nxt_s;

  keypad_row_prio_enc u_prio_enc (
    .row_i (bus.fila_i),
    .idx_o (enc_idx_s),
    .any_o (enc_any_s)
  );

  assign bus.col_o       = col_q;
  assign bus.key_code_o  = key_code_q;
  assign bus.key_valid_o = key_valid_q;
  assign bus.key_held_o  = key_held_q;

  // Next-state and output decode; nothing moves unless a scan tick is present.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    row_sel_s = bus.fila_i[row_idx_q];
    deb_nxt_s = (deb_cnt_q < DEB_LIM) ? (deb_cnt_q + 8'd1) : DEB_LIM;
    rel_nxt_s = (rel_cnt_q < REL_LIM) ? (rel_cnt_q + 8'd1) : REL_LIM;

    if (bus.en_tick_i) begin
      case (state_q)
        SCAN: begin
          if (enc_any_s) begin
            row_idx_d = enc_idx_s;
            deb_cnt_d = 8'd1;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_sel_s) begin
            deb_cnt_d = deb_nxt_s;
            if (deb_nxt_s >= DEB_LIM) begin
              state_d     = HELD;
              key_code_d  = pack_code(col_q, row_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            // Column is not advanced, so the same column is re-examined next tick.
            state_d   = SCAN;
            deb_cnt_d = 8'd0;
          end
        end
        HELD: begin
          if (!row_sel_s) begin
            rel_cnt_d = 8'd1;
            if (REL_LIM <= 8'd1) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              col_d      = col_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            state_d = HELD;
          end
        end
        RELEASE: begin
          if (!row_sel_s) begin
            rel_cnt_d = rel_nxt_s;
            if (rel_nxt_s >= REL_LIM) begin
              state_d    = SCAN;
              key_held_d = 1'b0;
              col_d      = col_q + 2'd1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            state_d   = HELD;
            rel_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= 8'd0;
      rel_cnt_q   <= 8'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl; accepted key codes are queued at stimulus time and popped on key_valid_o.
module tb_keypad_scan_ctrl;

  logic clk;
  logic rst_i;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];
  logic [3:0] last_code;

  keypad_scan_ctrl_if kp ();

  keypad_scan_ctrl #(
    .DEB_TICKS (4),
    .REL_TICKS (4)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (kp)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk edge: drive inputs, then sample 1 time unit after the edge.
  task automatic step(input logic rst_v, input logic tick, input logic [3:0] fila,
                      input logic [1:0] exp_col, input logic exp_held,
                      input logic exp_valid, input logic [3:0] exp_code, input string tag);
    logic [3:0] q_code;
    rst_i        = rst_v;
    kp.en_tick_i = tick;
    kp.fila_i    = fila;
    if (exp_valid) begin
      exp_q.push_back(exp_code);
      last_code = exp_code;
    end
    if (!rst_v) last_code = 4'd0;
    @(posedge clk);
    #1;
    check({tag, "/col"},   8'(kp.col_o),       8'(exp_col));
    check({tag, "/held"},  8'(kp.key_held_o),  8'(exp_held));
    check({tag, "/valid"}, 8'(kp.key_valid_o), 8'(exp_valid));
    if (kp.key_valid_o === 1'b1 && exp_q.size() > 0) begin
      q_code = exp_q.pop_front();
      check({tag, "/sb_code"}, 8'(kp.key_code_o), 8'(q_code));
    end
    check({tag, "/code"}, 8'(kp.key_code_o), 8'(last_code));
  endtask

  task automatic tk(input logic [3:0] fila, input logic [1:0] c, input logic h, input string tag);
    step(1'b1, 1'b1, fila, c, h, 1'b0, 4'd0, tag);
  endtask

  task automatic acc(input logic [3:0] fila, input logic [1:0] c, input logic [3:0] code, input string tag);
    step(1'b1, 1'b1, fila, c, 1'b1, 1'b1, code, tag);
  endtask

  task automatic idle(input logic [3:0] fila, input logic [1:0] c, input logic h, input string tag);
    step(1'b1, 1'b0, fila, c, h, 1'b0, 4'd0, tag);
  endtask

  task automatic rst(input logic [3:0] fila, input string tag);
    step(1'b0, 1'b1, fila, 2'd0, 1'b0, 1'b0, 4'd0, tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_code = 4'd0;
    rst_i        = 1'b0;
    kp.en_tick_i = 1'b0;
    kp.fila_i    = 4'd0;

    // Reset with coincident ticks and rows asserted
    rst(4'hF, "rst0");
    rst(4'hF, "rst1");

    // 1: idle scanning, column walks 1,2,3,0,1,2,3,0,1
    tk(4'h0, 2'd1, 1'b0, "scan1");
    tk(4'h0, 2'd2, 1'b0, "scan2");
    tk(4'h0, 2'd3, 1'b0, "scan3");
    tk(4'h0, 2'd0, 1'b0, "scan4");
    tk(4'h0, 2'd1, 1'b0, "scan5");
    tk(4'h0, 2'd2, 1'b0, "scan6");
    tk(4'h0, 2'd3, 1'b0, "scan7");
    tk(4'h0, 2'd0, 1'b0, "scan8");
    tk(4'h0, 2'd1, 1'b0, "scan9");
    idle(4'hF, 2'd1, 1'b0, "notick");
    tk(4'h0, 2'd2, 1'b0, "scan10");

    // 2: press row 2 on column 2, accepted on 4th tick
    tk(4'b0100, 2'd2, 1'b0, "deb1");
    tk(4'b0100, 2'd2, 1'b0, "deb2");
    idle(4'b0000, 2'd2, 1'b0, "deb_gap");
    tk(4'b0100, 2'd2, 1'b0, "deb3");
    acc(4'b0100, 2'd2, 4'b1010, "acc1");
    idle(4'b0100, 2'd2, 1'b1, "acc1_drop");
    tk(4'b0100, 2'd2, 1'b1, "held1");
    tk(4'b0100, 2'd2, 1'b1, "held2");
    tk(4'b0000, 2'd2, 1'b1, "rel1");
    tk(4'b0000, 2'd2, 1'b1, "rel2");
    tk(4'b0000, 2'd2, 1'b1, "rel3");
    tk(4'b0000, 2'd3, 1'b0, "rel4");

    // 3: bounce on column 3
    tk(4'b0001, 2'd3, 1'b0, "bnc1");
    tk(4'b0001, 2'd3, 1'b0, "bnc2");
    tk(4'b0000, 2'd3, 1'b0, "bnc3");
    tk(4'b0000, 2'd0, 1'b0, "bnc_adv");

    // 4: two rows on detection, row 1 wins; row 3 dropping is ignored
    tk(4'b1010, 2'd0, 1'b0, "prio1");
    tk(4'b0010, 2'd0, 1'b0, "prio2");
    tk(4'b0110, 2'd0, 1'b0, "prio3");
    acc(4'b0010, 2'd0, 4'b0001, "acc2");

    // 5: release interrupted by a high tick, then 4 consecutive lows
    tk(4'b0000, 2'd0, 1'b1, "r5_lo1");
    tk(4'b0000, 2'd0, 1'b1, "r5_lo2");
    tk(4'b0010, 2'd0, 1'b1, "r5_hi");
    tk(4'b0000, 2'd0, 1'b1, "r5_lo3");
    tk(4'b0000, 2'd0, 1'b1, "r5_lo4");
    tk(4'b0000, 2'd0, 1'b1, "r5_lo5");
    tk(4'b0000, 2'd1, 1'b0, "r5_lo6");

    // 6a: reset during debounce, coincident would-be accepting tick
    tk(4'b0100, 2'd1, 1'b0, "r6_deb1");
    tk(4'b0100, 2'd1, 1'b0, "r6_deb2");
    tk(4'b0100, 2'd1, 1'b0, "r6_deb3");
    rst(4'b0100, "r6_rst_deb");
    tk(4'b0000, 2'd1, 1'b0, "r6_scan1");

    // 6b: reset during held
    tk(4'b0001, 2'd1, 1'b0, "r6_h1");
    tk(4'b0001, 2'd1, 1'b0, "r6_h2");
    tk(4'b0001, 2'd1, 1'b0, "r6_h3");
    acc(4'b0001, 2'd1, 4'b0100, "acc3");
    tk(4'b0001, 2'd1, 1'b1, "r6_held");
    rst(4'b0000, "r6_rst_held");
    tk(4'b0000, 2'd1, 1'b0, "r6_scan2");
    tk(4'b0000, 2'd2, 1'b0, "r6_scan3");

    check("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
